// File: rtl/goose_game_ctrl.sv
// Game sequencer for the goose-run display: button debounce, per-frame
// goose/bean collision latch, IDLE/RUN/HIT/OVER FSM, score and speed tracking.
module goose_game_ctrl #(
   parameter int unsigned DEBOUNCE_CYCLES  = 1000000,
   parameter int unsigned FRAMES_PER_POINT = 6,
   parameter int unsigned POINTS_PER_LEVEL = 50,
   parameter int unsigned MAX_SPEED        = 15,
   parameter int unsigned HIT_FRAMES       = 60,
   parameter int unsigned SCORE_MAX        = 9999
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        btn_raw,
   input  logic        frame_tick,
   input  logic        video_on,
   input  logic        pix_goose,
   input  logic        pix_bean,
   output logic [1:0]  state,
   output logic        run_en,
   output logic        obstacle_restart,
   output logic        hit_flash,
   output logic [3:0]  scroll_speed,
   output logic [13:0] score,
   output logic [13:0] hi_score
);
   localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int FC_W = $clog2(FRAMES_PER_POINT + 1);
   localparam int LC_W = $clog2(POINTS_PER_LEVEL + 1);
   localparam int HC_W = $clog2(HIT_FRAMES + 1);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HIT = 2'd2, OVER = 2'd3} state_e;

   logic            sync1_q, sync2_q;
   logic [DB_W-1:0] db_cnt_q, db_cnt_d;
   logic            db_lvl_q, db_lvl_d;
   logic            press_q, press_d;

   state_e          state_q, state_d;
   logic            run_en_q, run_en_d;
   logic            restart_q, restart_d;
   logic            flash_q, flash_d;
   logic [3:0]      speed_q, speed_d;
   logic [13:0]     score_q, score_d;
   logic [13:0]     hi_q, hi_d;
   logic [FC_W-1:0] frame_cnt_q, frame_cnt_d;
   logic [LC_W-1:0] level_cnt_q, level_cnt_d;
   logic [HC_W-1:0] hit_cnt_q, hit_cnt_d;
   logic            hit_latch_q, hit_latch_d;
   logic            overlap;

   // Level flips only after DEBOUNCE_CYCLES straight cycles of disagreement.
   always_comb begin
      db_cnt_d = '0;
      db_lvl_d = db_lvl_q;
      press_d  = 1'b0;
      if (sync2_q != db_lvl_q) begin
         if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            db_lvl_d = sync2_q;
            press_d  = sync2_q;
         end else begin
            db_cnt_d = db_cnt_q + 1'b1;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      restart_d   = 1'b0;
      flash_d     = flash_q;
      speed_d     = speed_q;
      score_d     = score_q;
      hi_d        = hi_q;
      frame_cnt_d = frame_cnt_q;
      level_cnt_d = level_cnt_q;
      hit_cnt_d   = hit_cnt_q;
      overlap     = video_on & pix_goose & pix_bean & (state_q == RUN);
      // Old latch value is judged on frame_tick; overlap on that cycle seeds the next frame.
      hit_latch_d = frame_tick ? overlap : (hit_latch_q | overlap);
      case (state_q)
         IDLE, OVER: begin
            flash_d = 1'b0;
            if (press_q) begin
               state_d     = RUN;
               score_d     = '0;
               frame_cnt_d = '0;
               level_cnt_d = '0;
               speed_d     = 4'd1;
               restart_d   = 1'b1;
            end
         end
         RUN: begin
            if (frame_tick) begin
               if (hit_latch_q) begin
                  state_d   = HIT;
                  hit_cnt_d = '0;
               end else if (frame_cnt_q == FC_W'(FRAMES_PER_POINT - 1)) begin
                  frame_cnt_d = '0;
                  if (score_q != 14'(SCORE_MAX)) begin
                     score_d = score_q + 14'd1;
                     if (level_cnt_q == LC_W'(POINTS_PER_LEVEL - 1)) begin
                        level_cnt_d = '0;
                        if (speed_q != 4'(MAX_SPEED)) speed_d = speed_q + 4'd1;
                     end else begin
                        level_cnt_d = level_cnt_q + 1'b1;
                     end
                  end
               end else begin
                  frame_cnt_d = frame_cnt_q + 1'b1;
               end
            end
         end
         HIT: begin
            if (frame_tick) begin
               hit_cnt_d = hit_cnt_q + 1'b1;
               flash_d   = ~flash_q;
               if (hit_cnt_q == HC_W'(HIT_FRAMES - 1)) begin
                  state_d = OVER;
                  flash_d = 1'b0;
                  if (score_q > hi_q) hi_d = score_q;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      run_en_d = (state_d == RUN);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q     <= 1'b0;
         sync2_q     <= 1'b0;
         db_cnt_q    <= '0;
         db_lvl_q    <= 1'b0;
         press_q     <= 1'b0;
         state_q     <= IDLE;
         run_en_q    <= 1'b0;
         restart_q   <= 1'b0;
         flash_q     <= 1'b0;
         speed_q     <= 4'd1;
         score_q     <= '0;
         hi_q        <= '0;
         frame_cnt_q <= '0;
         level_cnt_q <= '0;
         hit_cnt_q   <= '0;
         hit_latch_q <= 1'b0;
      end else begin
         sync1_q     <= btn_raw;
         sync2_q     <= sync1_q;
         db_cnt_q    <= db_cnt_d;
         db_lvl_q    <= db_lvl_d;
         press_q     <= press_d;
         state_q     <= state_d;
         run_en_q    <= run_en_d;
         restart_q   <= restart_d;
         flash_q     <= flash_d;
         speed_q     <= speed_d;
         score_q     <= score_d;
         hi_q        <= hi_d;
         frame_cnt_q <= frame_cnt_d;
         level_cnt_q <= level_cnt_d;
         hit_cnt_q   <= hit_cnt_d;
         hit_latch_q <= hit_latch_d;
      end
   end

   assign state            = state_q;
   assign run_en           = run_en_q;
   assign obstacle_restart = restart_q;
   assign hit_flash        = flash_q;
   assign scroll_speed     = speed_q;
   assign score            = score_q;
   assign hi_score         = hi_q;
endmodule
